// File: rtl/sphere_scan_ctrl_if.sv
// Request, intersection-result and nearest-hit signals between the scan controller and its neighbours.
interface sphere_scan_ctrl_if #(
  parameter int IDX_W = 2
);
  logic             Px_start;
  logic             Px_ready;
  logic [IDX_W-1:0] Read_index;
  logic             Test_valid;
  logic             Isect_valid;
  logic             Isect_hit;
  logic [IDX_W-1:0] Isect_idx;
  logic [63:0]      Isect_t;
  logic             Res_valid;
  logic             Res_ready;
  logic             Hit;
  logic [IDX_W-1:0] Hit_index;
  logic [63:0]      Hit_t;
  logic [7:0]       Restart_cnt;

  // slave: the scan controller; master: requester, bank/intersection side and result consumer
  modport slave (
    input  Px_start, Isect_valid, Isect_hit, Isect_idx, Isect_t, Res_ready,
    output Px_ready, Read_index, Test_valid, Res_valid, Hit, Hit_index, Hit_t, Restart_cnt
  );
  modport master (
    output Px_start, Isect_valid, Isect_hit, Isect_idx, Isect_t, Res_ready,
    input  Px_ready, Read_index, Test_valid, Res_valid, Hit, Hit_index, Hit_t, Restart_cnt
  );
endinterface

// File: rtl/sphere_scan_ctrl.sv
// Per-pixel sphere scan: issues all indices, merges hits into a nearest tracker, rescans on frame edge.
// Result appears 6+L cycles after Px_start (L = intersection latency); Res_valid holds until Res_ready.
module sphere_scan_ctrl #(
  parameter int          NUM_SPHERES = 4,
  parameter int          IDX_W       = 2,
  parameter logic [63:0] T_MIN       = 64'h0000_0001_0000_0000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Frame_Clk,
  sphere_scan_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, DONE, FLUSH} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPHERES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W+1:0] OUT_ONE  = (IDX_W+2)'(1);

  state_t           state, state_nxt;
  logic             frame_q, frame_edge, abort;
  logic [IDX_W-1:0] read_index;
  logic             test_valid, issuing, px_ready, res_valid;
  logic [IDX_W+1:0] outstanding, outstanding_nxt;
  logic             drained, clear_tracker, merge;
  logic             hit;
  logic [IDX_W-1:0] hit_index;
  logic [63:0]      hit_t;
  logic [7:0]       restart_cnt;

  // Same edge detector as the sphere bank, so both see the update in the same cycle
  assign frame_edge = Frame_Clk & ~frame_q;
  assign abort      = frame_edge && (state == ISSUE || state == DRAIN);

  always_comb begin
    outstanding_nxt = outstanding;
    if (test_valid && !bus.Isect_valid)
      outstanding_nxt = outstanding + OUT_ONE;
    else if (!test_valid && bus.Isect_valid && outstanding != '0)
      outstanding_nxt = outstanding - OUT_ONE;
  end

  // Looking at the next count lets the final result leave DRAIN in the cycle it arrives
  assign drained = (outstanding_nxt == '0);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.Px_start) state_nxt = ISSUE;
      ISSUE:   if (frame_edge) state_nxt = FLUSH;
               else if (read_index == LAST_IDX) state_nxt = DRAIN;
      DRAIN:   if (frame_edge) state_nxt = FLUSH;
               else if (drained) state_nxt = DONE;
      DONE:    if (bus.Res_ready) state_nxt = IDLE;
      FLUSH:   if (!frame_edge && drained) state_nxt = ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    px_ready  = (state == IDLE);
    res_valid = (state == DONE);
    issuing   = (state == ISSUE) && !frame_edge;
  end

  assign clear_tracker = (state == IDLE && bus.Px_start) ||
                         (state == FLUSH && !frame_edge && drained);
  // Strict less-than keeps the earlier (lower) index on equal distances
  assign merge = bus.Isect_valid && (state == ISSUE || state == DRAIN) && bus.Isect_hit &&
                 (bus.Isect_t >= T_MIN) && (bus.Isect_t < hit_t);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_q     <= 1'b0;
      read_index  <= '0;
      test_valid  <= 1'b0;
      outstanding <= '0;
      restart_cnt <= 8'd0;
      hit         <= 1'b0;
      hit_index   <= '0;
      hit_t       <= '1;
    end else begin
      frame_q     <= Frame_Clk;
      test_valid  <= issuing;
      outstanding <= outstanding_nxt;
      if (clear_tracker)
        read_index <= '0;
      else if (issuing)
        read_index <= (read_index == LAST_IDX) ? '0 : read_index + IDX_ONE;
      if (abort && restart_cnt != 8'hFF)
        restart_cnt <= restart_cnt + 8'd1;
      if (clear_tracker) begin
        hit       <= 1'b0;
        hit_index <= '0;
        hit_t     <= '1;
      end else if (merge) begin
        hit       <= 1'b1;
        hit_index <= bus.Isect_idx;
        hit_t     <= bus.Isect_t;
      end
    end
  end

  assign bus.Px_ready    = px_ready;
  assign bus.Res_valid   = res_valid;
  assign bus.Read_index  = read_index;
  assign bus.Test_valid  = test_valid;
  assign bus.Hit         = hit;
  assign bus.Hit_index   = hit_index;
  assign bus.Hit_t       = hit_t;
  assign bus.Restart_cnt = restart_cnt;
endmodule

// File: tb/tb_sphere_scan_ctrl.sv
// Directed + random scans against an emulated intersection unit and a nearest-hit reference model.
module tb_sphere_scan_ctrl;
  localparam logic [63:0] T_MIN = 64'h0000_0001_0000_0000;

  typedef struct {
    int          due;
    logic [1:0]  idx;
    logic        hit;
    logic [63:0] t;
  } pend_t;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic Frame_Clk = 1'b0;
  sphere_scan_ctrl_if #(.IDX_W(2)) bus();

  sphere_scan_ctrl dut (.Clk(Clk), .Reset(Reset), .Frame_Clk(Frame_Clk), .bus(bus.slave));

  always #5 Clk = ~Clk;

  int          total = 0;
  int          bad = 0;
  int          lat_l = 4;
  int          cyc = 0;
  logic        tab_hit[4];
  logic [63:0] tab_t[4];
  pend_t       pq[$];
  logic [1:0]  prev_ri = 2'd0;
  int          ri_log[8];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Nearest valid hit: smallest distance at or above T_MIN, lowest index on a tie
  task automatic model(output logic h, output logic [1:0] idx, output logic [63:0] t);
    h = 1'b0; idx = 2'd0; t = '1;
    for (int i = 0; i < 4; i++)
      if (tab_hit[i] && tab_t[i] >= T_MIN)
        if (!h || tab_t[i] < t || (tab_t[i] == t && 2'(i) < idx)) begin
          h = 1'b1; idx = 2'(i); t = tab_t[i];
        end
  endtask

  task automatic rand_tab();
    for (int i = 0; i < 4; i++) begin
      tab_hit[i] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) tab_t[i] = {$urandom, $urandom};
      else tab_t[i] = 64'($urandom_range(0, 8)) << 31;
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #3;
  endtask

  task automatic run_scan(output int n);
    bus.Px_start = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      bus.Px_start = 1'b0;
      if (n < 8) ri_log[n] = int'(bus.Read_index);
    end while (!bus.Res_valid && n < 300);
  endtask

  task automatic check_res(input string tag);
    logic h; logic [1:0] idx; logic [63:0] t;
    model(h, idx, t);
    chk({tag, "_valid"}, 64'(bus.Res_valid), 64'd1);
    chk({tag, "_hit"}, 64'(bus.Hit), 64'(h));
    chk({tag, "_idx"}, 64'(bus.Hit_index), 64'(idx));
    chk({tag, "_t"}, bus.Hit_t, t);
  endtask

  task automatic accept(input string tag);
    bus.Res_ready = 1'b1;
    tick();
    bus.Res_ready = 1'b0;
    chk({tag, "_idle"}, {62'd0, bus.Px_ready, bus.Res_valid}, 64'b10);
  endtask

  // Intersection unit: the bank answers Read_index one cycle later, result follows L cycles after Test_valid
  initial begin
    bus.Isect_valid = 1'b0; bus.Isect_hit = 1'b0; bus.Isect_idx = 2'd0; bus.Isect_t = '0;
    forever begin
      pend_t e;
      @(posedge Clk);
      #1;
      cyc++;
      if (bus.Test_valid === 1'b1)
        pq.push_back('{due: cyc + lat_l, idx: prev_ri, hit: tab_hit[prev_ri], t: tab_t[prev_ri]});
      prev_ri = bus.Read_index;
      if (pq.size() > 0 && pq[0].due == cyc) begin
        e = pq.pop_front();
        bus.Isect_valid = 1'b1; bus.Isect_hit = e.hit; bus.Isect_idx = e.idx; bus.Isect_t = e.t;
      end else begin
        bus.Isect_valid = 1'b0;
      end
    end
  end

  initial begin
    int n, cnt;
    logic ok;
    logic [63:0] hold_t;
    logic [1:0]  hold_idx;
    logic        hold_hit;
    bus.Px_start = 1'b0;
    bus.Res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin tab_hit[i] = 1'b0; tab_t[i] = '0; end
    tick(); tick();
    chk("rst_px_ready", 64'(bus.Px_ready), 64'd1);
    chk("rst_read_index", 64'(bus.Read_index), 64'd0);
    chk("rst_flags", {61'd0, bus.Test_valid, bus.Res_valid, bus.Hit}, 64'd0);
    chk("rst_hit_t", bus.Hit_t, '1);
    chk("rst_restart", 64'(bus.Restart_cnt), 64'd0);
    Reset = 1'b0;
    tick();

    // Nearest hit with a tie between spheres 1 and 2
    lat_l = 4;
    tab_hit = '{1'b1, 1'b1, 1'b1, 1'b1};
    tab_t = '{64'h5_0000_0000, 64'h3_0000_0000, 64'h3_0000_0000, 64'h7_0000_0000};
    run_scan(n);
    chk("near_latency", 64'(n), 64'd10);
    for (int i = 1; i <= 4; i++) chk("near_read_index", 64'(ri_log[i]), 64'(i - 1));
    chk("near_hit", 64'(bus.Hit), 64'd1);
    chk("near_idx", 64'(bus.Hit_index), 64'd1);
    chk("near_t", bus.Hit_t, 64'h3_0000_0000);
    accept("near");

    // Only hit is below T_MIN
    tab_hit = '{1'b0, 1'b0, 1'b1, 1'b0};
    tab_t = '{64'h2_0000_0000, 64'h2_0000_0000, 64'h0_8000_0000, 64'h2_0000_0000};
    run_scan(n);
    chk("tmin_hit", 64'(bus.Hit), 64'd0);
    chk("tmin_idx", 64'(bus.Hit_index), 64'd0);
    chk("tmin_t", bus.Hit_t, 64'hFFFF_FFFF_FFFF_FFFF);
    accept("tmin");

    for (int k = 0; k < 12; k++) begin
      lat_l = $urandom_range(1, 6);
      rand_tab();
      run_scan(n);
      chk("rand_latency", 64'(n), 64'(6 + lat_l));
      check_res("rand");
      accept("rand");
    end

    // Abort while index 2 is on the bus; stale distances would otherwise win
    lat_l = 3;
    tab_hit = '{1'b1, 1'b1, 1'b1, 1'b1};
    tab_t = '{64'h1_8000_0000, 64'h1_8000_0000, 64'h1_8000_0000, 64'h1_8000_0000};
    bus.Px_start = 1'b1;
    n = 0;
    do begin tick(); bus.Px_start = 1'b0; n++; end while (bus.Read_index != 2'd2 && n < 20);
    Frame_Clk = 1'b1;
    tab_hit = '{1'b0, 1'b1, 1'b1, 1'b0};
    tab_t = '{64'h0, 64'h4_0000_0000, 64'h2_8000_0000, 64'h0};
    tick();
    Frame_Clk = 1'b0;
    chk("abort_restart", 64'(bus.Restart_cnt), 64'd1);
    chk("abort_stop", {62'd0, bus.Test_valid, bus.Px_ready}, 64'd0);
    cnt = int'(bus.Test_valid);
    n = 0;
    while (!bus.Res_valid && n < 100) begin
      tick(); n++;
      cnt += int'(bus.Test_valid);
    end
    chk("abort_rescan_issues", 64'(cnt), 64'd4);
    check_res("abort");
    chk("abort_idx_direct", 64'(bus.Hit_index), 64'd2);

    // Result held under backpressure, frame edge and Px_start in DONE are ignored
    hold_hit = bus.Hit; hold_idx = bus.Hit_index; hold_t = bus.Hit_t;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      Frame_Clk = (i == 5);
      bus.Px_start = (i >= 2 && i < 15);
      tick();
      if (!(bus.Res_valid === 1'b1 && bus.Px_ready === 1'b0 && bus.Hit === hold_hit &&
            bus.Hit_index === hold_idx && bus.Hit_t === hold_t)) ok = 1'b0;
    end
    bus.Px_start = 1'b0;
    Frame_Clk = 1'b0;
    chk("bp_stable", 64'(ok), 64'd1);
    chk("bp_restart", 64'(bus.Restart_cnt), 64'd1);
    accept("bp");

    // Reset with two results still in flight
    lat_l = 6;
    rand_tab();
    bus.Px_start = 1'b1;
    for (int i = 1; i <= 10; i++) begin tick(); bus.Px_start = 1'b0; end
    Reset = 1'b1;
    #1;
    Reset = 1'b0;
    #1;
    chk("mid_rst_flags", {60'd0, bus.Px_ready, bus.Test_valid, bus.Res_valid, bus.Hit}, 64'b1000);
    chk("mid_rst_idx", {60'd0, bus.Read_index, bus.Hit_index}, 64'd0);
    chk("mid_rst_t", bus.Hit_t, '1);
    chk("mid_rst_restart", 64'(bus.Restart_cnt), 64'd0);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); if (bus.Res_valid !== 1'b0) ok = 1'b1; end
    chk("late_no_result", 64'(ok), 64'd0);
    chk("late_outstanding", 64'(dut.outstanding), 64'd0);
    lat_l = 2;
    rand_tab();
    run_scan(n);
    chk("post_rst_latency", 64'(n), 64'd8);
    check_res("post_rst");
    accept("post_rst");

    // Back-to-back aborts until the counter saturates
    rand_tab();
    bus.Px_start = 1'b1;
    tick();
    bus.Px_start = 1'b0;
    for (int k = 0; k < 260; k++) begin
      n = 0;
      while (bus.Test_valid !== 1'b1 && n < 50) begin tick(); n++; end
      if (n >= 50) begin
        chk("sat_wait_timeout", 64'(k), 64'd260);
        break;
      end
      Frame_Clk = 1'b1;
      tick();
      Frame_Clk = 1'b0;
      if (k == 9) chk("sat_count10", 64'(bus.Restart_cnt), 64'd10);
    end
    chk("sat_restart", 64'(bus.Restart_cnt), 64'd255);
    n = 0;
    while (!bus.Res_valid && n < 100) begin tick(); n++; end
    check_res("sat");
    accept("sat");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sphere_scan_ctrl.md
Name: sphere_scan_ctrl

Overview:
Per-pixel scheduler for the sphere register bank and the ray-sphere intersection pipeline. On each pixel request it walks Read_index over all NUM_SPHERES spheres and tags each returned Sphere_pos for the intersection unit. It collects the hit results and reports the nearest hit: index and distance.
If a frame update occurs mid-scan, it aborts and rescans so that every pixel result comes from one consistent set of sphere positions.

Parameters:
NUM_SPHERES, 4, spheres scanned per pixel; must match the register bank.
IDX_W, 2, index width; equals clog2(NUM_SPHERES).
T_MIN, 64'h0000_0001_0000_0000 (1.0 in 32.32), minimum accepted hit distance; rejects self-intersection.

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
Frame_Clk  in  1  frame strobe, same signal the sphere bank uses for position updates
Px_start  in  1  start scan for current ray; accepted only when Px_ready=1
Px_ready  out  1  controller idle, can accept Px_start
Read_index  out  IDX_W  sphere index driven to the register bank
Test_valid  out  1  Sphere_pos/curr_index from the bank are valid this cycle (to intersection unit)
Isect_valid  in  1  intersection result valid
Isect_hit  in  1  ray hits sphere Isect_idx
Isect_idx  in  IDX_W  sphere index echoed through the pipeline
Isect_t  in  64  unsigned 32.32 hit distance
Res_valid  out  1  nearest-hit result valid; held until Res_ready
Res_ready  in  1  consumer accepts result
Hit  out  1  some sphere hit with t >= T_MIN
Hit_index  out  IDX_W  nearest sphere
Hit_t  out  64  nearest distance
Restart_cnt  out  8  saturating count of aborted scans

Behaviour:
- Reset values: state IDLE. Px_ready=1. Read_index=0. Test_valid=0. Res_valid=0. Hit=0, Hit_index=0, Hit_t=all ones. Restart_cnt=0. Outstanding=0. Frame edge register=0.
- Frame edge detection: register Frame_Clk each Clk. frame_edge = Frame_Clk & ~Frame_Clk_q, identical to the bank's detection. The bank therefore updates positions in the same cycle.
- State IDLE: Px_ready=1. When Px_start=1: clear the nearest tracker (Hit=0, Hit_t=all ones, Hit_index=0) and go to ISSUE with Read_index=0. A frame_edge in the same cycle does not abort.
- State ISSUE: spans NUM_SPHERES cycles. Read_index = 0,1,..,NUM_SPHERES-1, incrementing each cycle.
- Test_valid: a registered copy of the "issuing" flag. The bank output is registered, so Test_valid is high exactly 1 cycle after each Read_index.
- After the last index, go to DRAIN.
- State DRAIN: wait until Outstanding==0 and no Test_valid is pending, then go to DONE.
- Outstanding counter (width IDX_W+2): +1 when Test_valid=1, -1 when Isect_valid=1, unchanged when both occur. Underflow (Isect_valid with Outstanding==0 and no Test_valid) is ignored.
- Result merge, applied on each Isect_valid in ISSUE/DRAIN: a result is accepted when Isect_hit=1 and Isect_t >= T_MIN (unsigned compare) and Isect_t < Hit_t (strict). On acceptance: Hit=1, Hit_index=Isect_idx, Hit_t=Isect_t. Equal t keeps the earlier result, i.e. the lower index.
- State DONE: Res_valid=1. Hit, Hit_index and Hit_t are stable. Leave to IDLE in the cycle after Res_valid & Res_ready. frame_edge in DONE is ignored; the result is delivered.
- Abort: a frame_edge in ISSUE or DRAIN sends the controller to FLUSH. Restart_cnt increments, saturating at 255. Issuing stops that cycle.
- State FLUSH: Isect_valid results are counted down but not merged. When Outstanding==0 and no Test_valid is pending: clear the tracker and go to ISSUE at index 0.
- A frame_edge in FLUSH keeps the controller in FLUSH; Restart_cnt does not increment again.
- Latency, no abort, intersection latency L cycles from Test_valid to Isect_valid: Px_start sampled in cycle 0, Read_index 0..3 in cycles 1..4, Test_valid in cycles 2..5, Res_valid from cycle 6+L.
- Reset asserted mid-operation: all state returns to reset values immediately. Results arriving after reset deassertion with Outstanding==0 are ignored.

Test Plan:
- Nearest hit: L=4. t = {5.0, 3.0, 3.0, 7.0} for spheres 0..3, all hit. Expect Res_valid in cycle 10, Hit=1, Hit_index=1, Hit_t=64'h3_0000_0000.
- No hit / T_MIN: sphere 2 t=0.5 hit, others miss. Expect Hit=0, Hit_index=0, Hit_t=64'hFFFF_FFFF_FFFF_FFFF.
- Abort: Frame_Clk rises while Read_index=2. Expect Restart_cnt=1. Stale results are not merged, Read_index restarts at 0 after the drain, and the final result reflects only the post-edge results.
- Backpressure: Res_ready held 0 for 20 cycles in DONE plus a frame edge. Expect Res_valid and the outputs stable throughout, Px_ready=0, Px_start ignored. IDLE one cycle after Res_ready=1.
- Reset mid-DRAIN with 2 results outstanding. Expect all outputs at reset values. The late Isect_valid pulses cause no Res_valid, and Outstanding stays 0.
- Restart_cnt saturation: 260 aborted scans. Expect Restart_cnt=255.
